// File: rtl/nibble_receiver_if.sv
// rtl/nibble_receiver_if.sv - nibble input / word output handshake bundle for nibble_receiver
interface nibble_receiver_if #(
    parameter int WORD_NIBBLES = 4
);
    localparam int CW = $clog2(WORD_NIBBLES + 1);
    localparam int W  = 4 * WORD_NIBBLES;

    logic          data_valid;
    logic [3:0]    data;
    logic          data_ready;
    logic          flush;
    logic          word_valid;
    logic [W-1:0]  word;
    logic [CW-1:0] word_nibbles;
    logic          word_ready;

    modport slave (
        input  data_valid, data, flush, word_ready,
        output data_ready, word_valid, word, word_nibbles
    );

    modport master (
        output data_valid, data, flush, word_ready,
        input  data_ready, word_valid, word, word_nibbles
    );
endinterface

// File: rtl/nibble_receiver.sv
// rtl/nibble_receiver.sv - assembles 4-bit nibbles (LSB first) into words, with flush of partial words
module nibble_receiver #(
    parameter int WORD_NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    nibble_receiver_if.slave  bus
);
    localparam int CW = $clog2(WORD_NIBBLES + 1);
    localparam int W  = 4 * WORD_NIBBLES;
    localparam logic [CW-1:0] LAST = CW'(WORD_NIBBLES - 1);
    localparam logic [CW-1:0] FULL = CW'(WORD_NIBBLES);

    typedef enum logic {EMPTY, HOLD} out_state_t;

    out_state_t    state_q, state_d;
    logic [W-1:0]  asm_q, asm_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [W-1:0]  word_q, word_d;
    logic [CW-1:0] nib_q, nib_d;

    logic          hold;
    logic          out_free;
    logic          data_ready_c;
    logic          accept;
    logic [W-1:0]  filled;
    logic [W-1:0]  masked;

    assign hold         = (state_q == HOLD);
    assign out_free     = !hold || bus.word_ready;
    // Only the completing nibble needs a free output slot; partial nibbles keep flowing.
    assign data_ready_c = !bus.flush && !((fill_q == LAST) && hold && !bus.word_ready);
    assign accept       = bus.data_valid && data_ready_c;

    always_comb begin
        filled = asm_q;
        masked = asm_q;
        for (int i = 0; i < WORD_NIBBLES; i++) begin
            if (CW'(i) == fill_q) filled[4*i +: 4] = bus.data;
            if (CW'(i) >= fill_q) masked[4*i +: 4] = 4'h0;
        end
    end

    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        fill_d  = fill_q;
        word_d  = word_q;
        nib_d   = nib_q;
        if (hold && bus.word_ready) state_d = EMPTY;
        if (accept) begin
            if (fill_q == LAST) begin
                word_d  = filled;
                nib_d   = FULL;
                fill_d  = '0;
                asm_d   = '0;
                state_d = HOLD;
            end else begin
                asm_d  = filled;
                fill_d = fill_q + CW'(1);
            end
        end else if (bus.flush && (fill_q != '0) && out_free) begin
            word_d  = masked;
            nib_d   = fill_q;
            fill_d  = '0;
            asm_d   = '0;
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            asm_q   <= '0;
            fill_q  <= '0;
            word_q  <= '0;
            nib_q   <= '0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            fill_q  <= fill_d;
            word_q  <= word_d;
            nib_q   <= nib_d;
        end
    end

    assign bus.data_ready   = data_ready_c;
    assign bus.word_valid   = hold;
    assign bus.word         = word_q;
    assign bus.word_nibbles = nib_q;
endmodule

// File: tb/tb_nibble_receiver.sv
// tb/tb_nibble_receiver.sv - self-checking bench for nibble_receiver (WORD_NIBBLES=4)
module tb_nibble_receiver;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [15:0] w;
        logic [2:0]  n;
    } exp_t;

    typedef struct {
        logic [3:0]  n0, n1, n2, n3;
        logic [15:0] exp_word;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[4];

    nibble_receiver_if #(.WORD_NIBBLES(4)) bus ();
    nibble_receiver #(.WORD_NIBBLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] w, input logic [2:0] n);
        exp_t e;
        e.w = w;
        e.n = n;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] n);
        logic ok;
        ok = 1'b0;
        bus.data_valid = 1'b1;
        bus.data       = n;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = bus.data_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout nibble=%h actual=stalled required=accepted", n);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest expected word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=word %h required=no transfer", bus.word);
            end else begin
                e = sb.pop_front();
                chk("sb_word", 32'(bus.word), 32'(e.w));
                chk("sb_nibbles", 32'(bus.word_nibbles), 32'(e.n));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'h1, 4'h2, 4'h3, 4'h4, 16'h4321};
        vecs[1] = '{4'hF, 4'h0, 4'hA, 4'h5, 16'h5A0F};
        vecs[2] = '{4'h0, 4'h0, 4'h0, 4'h0, 16'h0000};
        vecs[3] = '{4'hC, 4'hF, 4'hE, 4'hB, 16'hBEFC};

        rst            = 1'b1;
        bus.data_valid = 1'b0;
        bus.data       = 4'h0;
        bus.flush      = 1'b0;
        bus.word_ready = 1'b1;
        #12;
        chk("rst_word_valid", 32'(bus.word_valid), 0);
        chk("rst_word", 32'(bus.word), 0);
        chk("rst_word_nibbles", 32'(bus.word_nibbles), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_data_ready", 32'(bus.data_ready), 1);

        // Full words, word_ready held high
        for (int v = 0; v < 4; v++) begin
            tick();
            push(vecs[v].exp_word, 3'd4);
            send(vecs[v].n0);
            send(vecs[v].n1);
            send(vecs[v].n2);
            send(vecs[v].n3);
            bus.data_valid = 1'b0;
            @(negedge clk);
            chk("latency_valid", 32'(bus.word_valid), 1);
            chk("latency_word", 32'(bus.word), 32'(vecs[v].exp_word));
            tick();
            @(negedge clk);
            chk("single_cycle_valid", 32'(bus.word_valid), 0);
        end

        // Backpressure: 1..8 with word_ready low
        tick();
        bus.word_ready = 1'b0;
        push(16'h4321, 3'd4);
        push(16'h8765, 3'd4);
        for (int i = 1; i <= 7; i++) send(4'(i));
        bus.data = 4'h8;
        @(negedge clk);
        chk("stall_data_ready", 32'(bus.data_ready), 0);
        chk("stall_word", 32'(bus.word), 32'h4321);
        tick();
        @(negedge clk);
        chk("stall_word_stable", 32'(bus.word), 32'h4321);
        tick();
        bus.word_ready = 1'b1;
        @(negedge clk);
        chk("drain_data_ready", 32'(bus.data_ready), 1);
        tick();
        bus.word_ready = 1'b0;
        bus.data_valid = 1'b0;
        @(negedge clk);
        chk("second_word_valid", 32'(bus.word_valid), 1);
        chk("second_word", 32'(bus.word), 32'h8765);
        tick();
        bus.word_ready = 1'b1;
        tick();

        // Flush of a partial word into an empty output, then a clean word
        push(16'h00BA, 3'd2);
        send(4'hA);
        send(4'hB);
        bus.data_valid = 1'b0;
        bus.flush      = 1'b1;
        @(negedge clk);
        chk("flush_data_ready", 32'(bus.data_ready), 0);
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(bus.word_valid), 1);
        chk("flush_nibbles", 32'(bus.word_nibbles), 2);
        tick();
        push(16'h4321, 3'd4);
        for (int i = 1; i <= 4; i++) send(4'(i));
        bus.data_valid = 1'b0;
        tick();

        // Flush with nothing buffered emits nothing
        bus.flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_empty_no_word", 32'(bus.word_valid), 0);
            tick();
        end
        bus.flush = 1'b0;

        // Flush blocked while output is held
        bus.word_ready = 1'b0;
        push(16'h4321, 3'd4);
        for (int i = 1; i <= 7; i++) send(4'(i));
        bus.data_valid = 1'b0;
        bus.flush      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_flush_word", 32'(bus.word), 32'h4321);
            tick();
        end
        push(16'h0765, 3'd3);
        bus.word_ready = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("held_flush_valid", 32'(bus.word_valid), 1);
        chk("held_flush_word2", 32'(bus.word), 32'h0765);
        chk("held_flush_nibbles", 32'(bus.word_nibbles), 3);
        tick();
        @(negedge clk);
        chk("held_flush_done", 32'(bus.word_valid), 0);
        tick();

        // Asynchronous reset mid-cycle with a held word and a partial word
        bus.word_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send(4'(i));
        bus.data_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.word_valid), 0);
        chk("async_rst_word", 32'(bus.word), 0);
        chk("async_rst_nibbles", 32'(bus.word_nibbles), 0);
        tick();
        rst            = 1'b0;
        bus.word_ready = 1'b1;
        @(negedge clk);
        chk("rst2_data_ready", 32'(bus.data_ready), 1);
        tick();
        push(16'h8765, 3'd4);
        for (int i = 5; i <= 8; i++) send(4'(i));
        bus.data_valid = 1'b0;
        @(negedge clk);
        chk("rst2_word", 32'(bus.word), 32'h8765);
        tick();

        // Completing nibble and drain in the same cycle: no bubble
        bus.word_ready = 1'b0;
        push(16'h4321, 3'd4);
        push(16'h8765, 3'd4);
        for (int i = 1; i <= 7; i++) send(4'(i));
        bus.data       = 4'h8;
        bus.word_ready = 1'b1;
        @(negedge clk);
        chk("nobubble_data_ready", 32'(bus.data_ready), 1);
        tick();
        bus.data_valid = 1'b0;
        @(negedge clk);
        chk("nobubble_valid", 32'(bus.word_valid), 1);
        chk("nobubble_word", 32'(bus.word), 32'h8765);
        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
